// File: rtl/multicycle_control_pkg.sv
// multicycle_control_pkg
// Shared definitions for the multi-cycle control sequencer: opcode constants,
// ALU function codes, FSM state encoding and an opcode classifier used by the
// DECODE state.
package multicycle_control_pkg;

    // Opcodes (Instr[31:26])
    localparam logic [5:0] OP_RTYPE = 6'b100000;
    localparam logic [5:0] OP_ADDI  = 6'b110000;
    localparam logic [5:0] OP_ANDI  = 6'b110010;
    localparam logic [5:0] OP_ORI   = 6'b110011;
    localparam logic [5:0] OP_LI    = 6'b111000;
    localparam logic [5:0] OP_LUI   = 6'b111001;
    localparam logic [5:0] OP_B     = 6'b111111;
    localparam logic [5:0] OP_BEQ   = 6'b000000;
    localparam logic [5:0] OP_BNE   = 6'b000001;
    localparam logic [5:0] OP_LB    = 6'b000011;
    localparam logic [5:0] OP_LW    = 6'b001111;
    localparam logic [5:0] OP_SB    = 6'b000111;
    localparam logic [5:0] OP_SW    = 6'b011111;

    // ALU function codes
    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_AND = 4'b0010;
    localparam logic [3:0] ALU_OR  = 4'b0011;

    typedef enum logic [3:0] {
        StIfetch,
        StDecode,
        StExAlu,
        StExAddr,
        StMemRd,
        StMemWr,
        StWbAlu,
        StWbMem,
        StBranch
    } state_e;

    typedef enum logic [2:0] {
        ClsAlu,
        ClsLoad,
        ClsStore,
        ClsBranch,
        ClsIllegal
    } op_class_e;

    function automatic op_class_e classify(input logic [5:0] op);
        op_class_e cls;
        case (op)
            OP_RTYPE, OP_ADDI, OP_ANDI, OP_ORI, OP_LI, OP_LUI: cls = ClsAlu;
            OP_LB, OP_LW:                                      cls = ClsLoad;
            OP_SB, OP_SW:                                      cls = ClsStore;
            OP_B, OP_BEQ, OP_BNE:                              cls = ClsBranch;
            default:                                           cls = ClsIllegal;
        endcase
        return cls;
    endfunction

endpackage

// File: rtl/multicycle_control_retire_counter.sv
// retire_counter
// Free-running enable counter of completed instructions. Wraps silently from
// all-ones to zero.
// Ports:
//   i_clk   - clock, rising edge
//   i_rst   - asynchronous active-high reset, clears the count
//   i_en    - increment on the next rising edge
//   o_count - current count
module retire_counter #(
    parameter int unsigned RETIRE_W = 32
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_en,
    output logic [RETIRE_W-1:0] o_count
);

    logic [RETIRE_W-1:0] r_count;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= r_count + RETIRE_W'(1);
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/multicycle_control.sv
// multicycle_control
// Multi-cycle sequencer that steps the datapath through fetch, decode,
// execute, memory and write-back states, one instruction at a time.
// Ports:
//   Clk, Reset    - clock (rising edge), asynchronous active-high reset
//   Instr         - contents of the instruction register (stable after IFETCH)
//   Zero          - ALU zero flag, used combinationally in BRANCH
//   IR_LdEn       - load instruction register (IFETCH)
//   PC_LdEn       - load PC, exactly once per instruction in its final state
//   PC_Sel        - 0: PC+4, 1: branch target
//   RF_WrEn       - register-file write
//   RF_WrData_sel - 0: ALU result, 1: memory data
//   RF_B_sel      - register-file B read port select
//   ALU_Bin_sel   - 0: RF B, 1: immediate
//   ALU_func      - ALU operation
//   Mem_WrEn      - data-memory write
//   Byte_Op       - byte-sized memory access (lb/sb)
//   Illegal       - one-cycle pulse in DECODE for an unknown opcode
//   Retired       - instructions completed since reset
module multicycle_control
    import multicycle_control_pkg::*;
#(
    parameter int unsigned RETIRE_W = 32
) (
    input  logic                Clk,
    input  logic                Reset,
    input  logic [31:0]         Instr,
    input  logic                Zero,
    output logic                IR_LdEn,
    output logic                PC_LdEn,
    output logic                PC_Sel,
    output logic                RF_WrEn,
    output logic                RF_WrData_sel,
    output logic                RF_B_sel,
    output logic                ALU_Bin_sel,
    output logic [3:0]          ALU_func,
    output logic                Mem_WrEn,
    output logic                Byte_Op,
    output logic                Illegal,
    output logic [RETIRE_W-1:0] Retired
);

    state_e    r_state;
    logic [5:0] w_opcode;
    op_class_e w_class;
    logic      w_retire_en;
    logic      unused_instr;

    assign w_opcode     = Instr[31:26];
    assign w_class      = classify(w_opcode);
    assign unused_instr = ^Instr[25:4];

    // FSM
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state <= StIfetch;
        end else begin
            case (r_state)
                StIfetch: r_state <= StDecode;
                StDecode: begin
                    case (w_class)
                        ClsAlu:            r_state <= StExAlu;
                        ClsLoad, ClsStore: r_state <= StExAddr;
                        ClsBranch:         r_state <= StBranch;
                        default:           r_state <= StIfetch;
                    endcase
                end
                StExAlu:  r_state <= StWbAlu;
                StExAddr: r_state <= (w_class == ClsStore) ? StMemWr : StMemRd;
                StMemRd:  r_state <= StWbMem;
                default:  r_state <= StIfetch;
            endcase
        end
    end

    // Retire on the final state of every legal instruction; illegal opcodes
    // leave from DECODE and are never counted.
    assign w_retire_en = !Reset &&
                         (r_state inside {StWbAlu, StWbMem, StMemWr, StBranch});

    retire_counter #(
        .RETIRE_W (RETIRE_W)
    ) u_retire_counter (
        .i_clk   (Clk),
        .i_rst   (Reset),
        .i_en    (w_retire_en),
        .o_count (Retired)
    );

    // Output decode. Everything is forced low while Reset is held so nothing
    // fires during an aborted instruction.
    always_comb begin
        IR_LdEn       = 1'b0;
        PC_LdEn       = 1'b0;
        PC_Sel        = 1'b0;
        RF_WrEn       = 1'b0;
        RF_WrData_sel = 1'b0;
        RF_B_sel      = 1'b0;
        ALU_Bin_sel   = 1'b0;
        ALU_func      = ALU_ADD;
        Mem_WrEn      = 1'b0;
        Byte_Op       = 1'b0;
        Illegal       = 1'b0;
        if (!Reset) begin
            case (r_state)
                StIfetch: IR_LdEn = 1'b1;
                StDecode: begin
                    if (w_class == ClsIllegal) begin
                        Illegal = 1'b1;
                        PC_LdEn = 1'b1;
                    end
                end
                StExAlu: begin
                    case (w_opcode)
                        OP_RTYPE: begin
                            ALU_func    = Instr[3:0];
                            ALU_Bin_sel = 1'b0;
                        end
                        OP_ANDI: begin
                            ALU_func    = ALU_AND;
                            ALU_Bin_sel = 1'b1;
                        end
                        OP_ORI: begin
                            ALU_func    = ALU_OR;
                            ALU_Bin_sel = 1'b1;
                        end
                        default: begin
                            ALU_func    = ALU_ADD;
                            ALU_Bin_sel = 1'b1;
                        end
                    endcase
                end
                StWbAlu: begin
                    RF_WrEn = 1'b1;
                    PC_LdEn = 1'b1;
                end
                StExAddr: begin
                    ALU_func    = ALU_ADD;
                    ALU_Bin_sel = 1'b1;
                    RF_B_sel    = 1'b1;
                end
                StMemRd: Byte_Op = (w_opcode == OP_LB);
                StWbMem: begin
                    RF_WrEn       = 1'b1;
                    RF_WrData_sel = 1'b1;
                    Byte_Op       = (w_opcode == OP_LB);
                    PC_LdEn       = 1'b1;
                end
                StMemWr: begin
                    Mem_WrEn = 1'b1;
                    RF_B_sel = 1'b1;
                    Byte_Op  = (w_opcode == OP_SB);
                    PC_LdEn  = 1'b1;
                end
                StBranch: begin
                    ALU_func = ALU_SUB;
                    RF_B_sel = 1'b1;
                    PC_LdEn  = 1'b1;
                    case (w_opcode)
                        OP_B:    PC_Sel = 1'b1;
                        OP_BEQ:  PC_Sel = Zero;
                        default: PC_Sel = !Zero;
                    endcase
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: one 32-bit-counter instance and one 4-bit
// instance share stimulus; each instruction is checked against a
// per-instruction expectation (cycle count, strobe counts, selects).
module tb_multicycle_control;

    logic        Clk = 1'b0;
    logic        Reset;
    logic [31:0] Instr;
    logic        Zero;

    logic        IR_LdEn, PC_LdEn, PC_Sel, RF_WrEn, RF_WrData_sel, RF_B_sel;
    logic        ALU_Bin_sel, Mem_WrEn, Byte_Op, Illegal;
    logic [3:0]  ALU_func;
    logic [31:0] Retired;

    logic        d4_ir, d4_pc, d4_pcsel, d4_rfwr, d4_wdsel, d4_bsel, d4_bin;
    logic        d4_memwr, d4_byte, d4_ill;
    logic [3:0]  d4_func;
    logic [3:0]  d4_retired;

    int     n_tests = 0;
    int     n_fail  = 0;
    longint model_ret = 0;

    multicycle_control #(.RETIRE_W(32)) dut (
        .Clk(Clk), .Reset(Reset), .Instr(Instr), .Zero(Zero),
        .IR_LdEn(IR_LdEn), .PC_LdEn(PC_LdEn), .PC_Sel(PC_Sel), .RF_WrEn(RF_WrEn),
        .RF_WrData_sel(RF_WrData_sel), .RF_B_sel(RF_B_sel), .ALU_Bin_sel(ALU_Bin_sel),
        .ALU_func(ALU_func), .Mem_WrEn(Mem_WrEn), .Byte_Op(Byte_Op), .Illegal(Illegal),
        .Retired(Retired)
    );

    multicycle_control #(.RETIRE_W(4)) dut4 (
        .Clk(Clk), .Reset(Reset), .Instr(Instr), .Zero(Zero),
        .IR_LdEn(d4_ir), .PC_LdEn(d4_pc), .PC_Sel(d4_pcsel), .RF_WrEn(d4_rfwr),
        .RF_WrData_sel(d4_wdsel), .RF_B_sel(d4_bsel), .ALU_Bin_sel(d4_bin),
        .ALU_func(d4_func), .Mem_WrEn(d4_memwr), .Byte_Op(d4_byte), .Illegal(d4_ill),
        .Retired(d4_retired)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Write strobes must never coincide, on either instance.
    always @(negedge Clk) begin
        chk("rf_mem_excl", {31'd0, RF_WrEn & Mem_WrEn}, 32'd0);
        chk("rf_mem_excl4", {31'd0, d4_rfwr & d4_memwr}, 32'd0);
    end

    // Reference: instruction classes 0 alu, 1 load, 2 store, 3 branch, 4 illegal
    function automatic int op_class(input logic [5:0] op);
        case (op)
            6'b100000, 6'b110000, 6'b110010, 6'b110011, 6'b111000, 6'b111001: return 0;
            6'b000011, 6'b001111: return 1;
            6'b000111, 6'b011111: return 2;
            6'b111111, 6'b000000, 6'b000001: return 3;
            default: return 4;
        endcase
    endfunction

    function automatic int exp_cycles(input int cls);
        case (cls)
            0: return 4;
            1: return 5;
            2: return 4;
            3: return 3;
            default: return 2;
        endcase
    endfunction

    function automatic logic [3:0] exp_func(input logic [31:0] ins);
        case (ins[31:26])
            6'b100000: return ins[3:0];
            6'b110010: return 4'b0010;
            6'b110011: return 4'b0011;
            6'b111111, 6'b000000, 6'b000001: return 4'b0001;
            default: return 4'b0000;
        endcase
    endfunction

    function automatic logic exp_pcsel(input logic [31:0] ins, input logic z);
        case (ins[31:26])
            6'b111111: return 1'b1;
            6'b000000: return z;
            6'b000001: return !z;
            default:   return 1'b0;
        endcase
    endfunction

    // Called at a falling edge with the DUT in IFETCH; returns at the falling
    // edge of the following IFETCH.
    task automatic run_instr(input logic [31:0] ins, input logic z);
        int   cls;
        int   cyc = 0;
        bit   done = 0;
        int   ir_cnt = 0, ir_cyc = -1, wr_cnt = 0, wr_cyc = -1, mem_cnt = 0;
        int   ill_cnt = 0, ill_cyc = -1;
        logic wr_sel = 1'b0, pcsel = 1'b0, byte3 = 1'b0, last_byte = 1'b0;
        logic ex_bin = 1'b0, ex_bsel = 1'b0;
        logic [3:0] ex_func = 4'h0;
        string op;
        Instr = ins;
        Zero  = z;
        cls   = op_class(ins[31:26]);
        op    = $sformatf("op=%b", ins[31:26]);
        while (!done && cyc < 8) begin
            #1;
            if (IR_LdEn) begin ir_cnt++; ir_cyc = cyc; end
            if (RF_WrEn) begin wr_cnt++; wr_cyc = cyc; wr_sel = RF_WrData_sel; end
            if (Mem_WrEn) mem_cnt++;
            if (Illegal) begin ill_cnt++; ill_cyc = cyc; end
            if (cyc == 2) begin ex_func = ALU_func; ex_bin = ALU_Bin_sel; ex_bsel = RF_B_sel; end
            if (cyc == 3) byte3 = Byte_Op;
            if (PC_LdEn) begin done = 1; pcsel = PC_Sel; last_byte = Byte_Op; end
            @(negedge Clk);
            cyc++;
        end
        if (!done) cyc = 99;
        chk({"cycles ", op}, cyc, exp_cycles(cls));
        chk({"ir_ld ", op}, {ir_cnt[15:0], ir_cyc[15:0]}, {16'd1, 16'd0});
        chk({"pc_sel ", op}, {31'd0, pcsel}, {31'd0, exp_pcsel(ins, z)});
        chk({"mem_wr ", op}, mem_cnt, (cls == 2) ? 1 : 0);
        chk({"illegal ", op}, {ill_cnt[15:0], ill_cyc[15:0]},
            (cls == 4) ? {16'd1, 16'd1} : {16'd0, 16'hffff});
        if (cls == 0 || cls == 1)
            chk({"rf_wr ", op}, {wr_cnt[7:0], wr_cyc[7:0], 15'd0, wr_sel},
                {8'd1, 8'(exp_cycles(cls) - 1), 15'd0, (cls == 1)});
        else
            chk({"rf_wr ", op}, wr_cnt, 0);
        if (cls != 4) begin
            chk({"alu_func ", op}, {28'd0, ex_func}, {28'd0, exp_func(ins)});
            chk({"alu_bin ", op}, {31'd0, ex_bin},
                {31'd0, !(cls == 3 || ins[31:26] == 6'b100000)});
        end
        if (cls != 0 && cls != 4) chk({"rf_b_sel ", op}, {31'd0, ex_bsel}, 32'd1);
        if (ins[31:26] == 6'b100000) chk({"rf_b_sel ", op}, {31'd0, ex_bsel}, 32'd0);
        if (cls == 1) begin
            chk({"byte_rd ", op}, {30'd0, byte3, last_byte},
                {30'd0, {2{ins[31:26] == 6'b000011}}});
        end
        if (cls == 2) chk({"byte_wr ", op}, {31'd0, last_byte}, {31'd0, ins[31:26] == 6'b000111});
        if (cls != 4) model_ret++;
        #1;
        chk({"retired ", op}, Retired, model_ret[31:0]);
        chk({"retired4 ", op}, {28'd0, d4_retired}, {28'd0, model_ret[3:0]});
    endtask

    function automatic logic [31:0] strobes();
        return {20'd0, IR_LdEn, PC_LdEn, PC_Sel, RF_WrEn, RF_WrData_sel, RF_B_sel,
                ALU_Bin_sel, Mem_WrEn, Byte_Op, Illegal, 2'b00} | {28'd0, ALU_func};
    endfunction

    logic [5:0]  legal [13] = '{6'b100000, 6'b110000, 6'b110010, 6'b110011, 6'b111000,
                                6'b111001, 6'b111111, 6'b000000, 6'b000001, 6'b000011,
                                6'b001111, 6'b000111, 6'b011111};

    initial begin
        logic [31:0] add_ins;
        logic [5:0]  rop;
        add_ins = {6'b100000, 5'd1, 5'd2, 5'd3, 7'd0, 4'b0000};
        Reset = 1'b1;
        Instr = 32'd0;
        Zero  = 1'b0;
        repeat (3) @(negedge Clk);
        #1;
        chk("reset_strobes", strobes(), 32'd0);
        chk("reset_retired", Retired, 32'd0);
        Reset = 1'b0;

        // Abort an add in EX_ALU
        Instr = add_ins;
        @(negedge Clk);
        @(negedge Clk);
        Reset = 1'b1;
        #1;
        chk("abort_strobes", strobes(), 32'd0);
        chk("abort_retired", Retired, 32'd0);
        @(negedge Clk);
        Reset = 1'b0;
        #1;
        chk("abort_ifetch", strobes(), {20'd0, 1'b1, 11'd0});
        chk("abort_retired2", Retired, 32'd0);

        run_instr(add_ins, 1'b0);
        run_instr({6'b001111, 26'h0123456}, 1'b0);      // lw
        run_instr({6'b000111, 26'h0abcdef}, 1'b1);      // sb
        run_instr({6'b000000, 26'h0000010}, 1'b1);      // beq taken
        run_instr({6'b000000, 26'h0000010}, 1'b0);      // beq not taken
        run_instr({6'b000001, 26'h0000020}, 1'b0);      // bne taken
        run_instr({6'b111111, 26'h0000030}, 1'b0);      // b
        run_instr({6'b101010, 26'h1555555}, 1'b0);      // illegal
        repeat (16) run_instr({6'b110000, 26'h0000007}, 1'b0);  // addi x16: 4-bit wrap

        for (int i = 0; i < 80; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                rop = 6'($urandom);
                while (op_class(rop) != 4) rop = 6'($urandom);
            end else begin
                rop = legal[$urandom_range(0, 12)];
            end
            run_instr({rop, 26'($urandom)}, 1'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
